rotate_sequencer: RTL
=====================

# rotate_sequencer

Multi-cycle controller that sequences a bit-manipulation datapath: rotate-left, rotate-right, pair-copy and bit-reverse on a WIDTH-bit word. Rotations by N positions run as N single-position steps under an FSM with a cycle counter. Sits between a valid/ready command producer and a valid/ready result consumer, and owns the single shared step datapath.

## Interface
- WIDTH, 4: data word width; must be even and ≥ 2.
- AMT_W, $clog2(WIDTH): width of the rotate amount field (derived, not overridden).
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  sequencer can accept a command.
- in_op  in  2  operation: 0 ROTL, 1 ROTR, 2 COPY2, 3 REV.
- in_amount  in  AMT_W  rotate distance, 0..WIDTH-1; ignored for COPY2/REV.
- in_data  in  WIDTH  operand.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_data  out  WIDTH  result word.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch op, data and count=amount.
  - ROTL/ROTR with amount>0 → RUN.
  - ROTL/ROTR with amount=0 → DONE, data unchanged.
  - COPY2 → DONE with data={2{in_data[WIDTH/2-1:0]}}.
  - REV → DONE with data bit-reversed (bit i ← bit WIDTH-1-i).
- RUN: each edge rotates latched data one position (ROTL: {d[W-2:0],d[W-1]}; ROTR: {d[0],d[W-1:1]}) and decrements count; the edge that takes count from 1 to 0 moves to DONE.
- DONE: out_valid=1, out_data=latched data, held stable until out_ready; out_valid&&out_ready → IDLE.
- in_ready=0 in RUN and DONE; in_valid is ignored there. No abort; commands are never dropped once accepted.
- out_data holds its last value in IDLE and RUN; it is meaningful only while out_valid=1.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, count=0.

## Timing
- Command accepted in cycle C: out_valid first high in cycle C+1+k, where k=amount for ROTL/ROTR and k=0 for COPY2/REV.
- Minimum handshake-to-handshake period: k+2 cycles (accept, k steps, result). A new command cannot be accepted in the same cycle the result is taken.
- Backpressure: out_valid stays high and out_data stays constant for any number of cycles with out_ready=0.
- out_ready while out_valid=0 has no effect.
- rst asserted in any state (including mid-RUN) forces reset values immediately, with no clock edge required. The first command is accepted on the first edge after rst deasserts.

## Configuration
- ROTATE_SEQ_STATS_EN defined: adds output done_count [15:0], reset 0. It increments on every out_valid&&out_ready and wraps 16'hFFFF→0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package rotate_seq_pkg:
  - op_e enum (ROTL=0, ROTR=1, COPY2=2, REV=3).
  - state_e enum (IDLE, RUN, DONE).
  - Default WIDTH constant.
- Sub-module rotate_step_unit: combinational, inputs op_e and a WIDTH word. Outputs a one-position rotate for ROTL/ROTR, the pair-copy for COPY2 and the bit reverse for REV. The FSM instantiates it once and uses it both at accept and in RUN.

## Test plan
- ROTL, data 4'b1001, amount 1: out_valid in cycle C+2, out_data 4'b0011.
- ROTR, data 4'b1001, amount 3: out_valid in cycle C+4, out_data 4'b0011; busy high for 4 cycles; in_valid pulses during RUN are ignored.
- COPY2 4'b0110 → 4'b1010; REV 4'b0001 → 4'b1000; ROTL amount 0 on 4'b1100 → 4'b1100; each with out_valid in cycle C+1.
- out_ready held low 5 cycles in DONE: out_valid and out_data stable, in_ready=0. Then out_ready=1 gives IDLE next cycle, and a new command is accepted one cycle after that.
- rst pulsed mid-RUN of ROTL amount 3: out_valid=0, in_ready=1 and busy=0 immediately. The next command completes correctly.
- With ROTATE_SEQ_STATS_EN: 3 completed commands give done_count=3. Preload to 16'hFFFF via 65535 completions, or force in sim; one more completion wraps it to 0.

Source files
------------

// File: rtl/rotate_seq_pkg.sv
// rotate_seq_pkg: shared types and constants for the rotate sequencer.
//   op_e    - command opcode (ROTL, ROTR, COPY2, REV)
//   state_e - sequencer FSM states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH - default data word width
`timescale 1ns/1ps
package rotate_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ROTL  = 2'd0,
    ROTR  = 2'd1,
    COPY2 = 2'd2,
    REV   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rotate_step_unit.sv
// rotate_step_unit: combinational single-step bit-manipulation datapath.
// Ports:
//   op       in  op_e        operation to apply
//   data_in  in  WIDTH       operand
//   data_out out WIDTH       ROTL/ROTR: rotated by one position,
//                            COPY2: low half replicated, REV: bit reverse
`timescale 1ns/1ps
module rotate_step_unit
  import rotate_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] rev_data;

  // Bit reverse: bit gi takes bit WIDTH-1-gi.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign rev_data[gi] = data_in[WIDTH-1-gi];
    end
  endgenerate

  always_comb begin
    data_out = data_in;
    case (op)
      ROTL:    data_out = {data_in[WIDTH-2:0], data_in[WIDTH-1]};
      ROTR:    data_out = {data_in[0], data_in[WIDTH-1:1]};
      COPY2:   data_out = {2{data_in[WIDTH/2-1:0]}};
      REV:     data_out = rev_data;
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/rotate_sequencer.sv
// rotate_sequencer: multi-cycle controller for rotate/copy/reverse commands.
// A rotation by N is executed as N single-position steps through the shared
// rotate_step_unit; COPY2 and REV use the same unit once at accept time.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    command handshake (in_op, in_amount, in_data)
//   out_valid/out_ready  result handshake (out_data)
//   busy                 high while a command is in RUN or DONE
//   done_count [15:0]    completed-result counter, present only when
//                        ROTATE_SEQ_STATS_EN is defined
// WIDTH must be even and at least 2.
`timescale 1ns/1ps
module rotate_sequencer
  import rotate_seq_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [AMT_W-1:0] in_amount,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef ROTATE_SEQ_STATS_EN
  ,
  output logic [15:0]      done_count
`endif
);

  state_e           state_reg, state_next;
  op_e              op_reg, op_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [AMT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] out_data_reg;
  logic             load_out;

  op_e              step_op;
  logic [WIDTH-1:0] step_in;
  logic [WIDTH-1:0] step_out;

  // The single step unit sees the incoming command while idle and the
  // latched working word otherwise.
  rotate_step_unit #(.WIDTH(WIDTH)) u_step (
    .op       (step_op),
    .data_in  (step_in),
    .data_out (step_out)
  );

  always_comb begin
    step_op = op_reg;
    step_in = data_reg;
    if (state_reg == IDLE) begin
      step_op = op_e'(in_op);
      step_in = in_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    data_next  = data_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          op_next    = op_e'(in_op);
          count_next = in_amount;
          if (op_e'(in_op) == ROTL || op_e'(in_op) == ROTR) begin
            // Rotations start from the raw operand; steps happen in RUN.
            data_next  = in_data;
            state_next = (in_amount != '0) ? RUN : DONE;
          end else begin
            data_next  = step_out;
            state_next = DONE;
          end
        end
      end
      RUN: begin
        data_next  = step_out;
        count_next = count_reg - AMT_W'(1);
        if (count_reg == AMT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The visible result register only changes when a result is published,
  // so out_data holds its previous value through IDLE and RUN.
  assign load_out = (state_next == DONE) && (state_reg != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      op_reg       <= ROTL;
      data_reg     <= '0;
      count_reg    <= '0;
      out_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      data_reg  <= data_next;
      count_reg <= count_next;
      if (load_out) begin
        out_data_reg <= data_next;
      end
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_data  = out_data_reg;

`ifdef ROTATE_SEQ_STATS_EN
  logic [15:0] done_count_reg;

  // Wraps naturally from 16'hFFFF to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_count_reg <= '0;
    end else if (out_valid && out_ready) begin
      done_count_reg <= done_count_reg + 16'd1;
    end
  end

  assign done_count = done_count_reg;
`endif

endmodule
